// File: rtl/galvo_point_scheduler.sv
// Point FIFO and sequencer feeding the galvo DAC, one point per update strobe.
// Define GALVO_SCHED_SETTLE_EN to add large-jump blanking with a slowed settle period.
module galvo_point_scheduler #(
    parameter int COORD_W        = 12,
    parameter int DEPTH          = 16,
    parameter int PRIME          = 4,
    parameter int JUMP_THRESH    = 256,
    parameter int SETTLE_STROBES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     strobe_in,
    input  logic [1:0]               base_rate,
    input  logic                     pt_valid,
    input  logic [COORD_W-1:0]       pt_x,
    input  logic [COORD_W-1:0]       pt_y,
    input  logic                     pt_laser,
    input  logic                     pt_last,
    output logic                     pt_ready,
    output logic [COORD_W-1:0]       dac_x,
    output logic [COORD_W-1:0]       dac_y,
    output logic                     dac_load,
    output logic                     laser_en,
    output logic [1:0]               rate_setting,
    output logic                     frame_done,
    output logic                     underflow,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = 3 + 2 * COORD_W;
    localparam logic [AW:0]          DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]          PRIME_C = (AW+1)'(PRIME);
    localparam logic [COORD_W-1:0]   CENTRE  = {1'b1, {(COORD_W-1){1'b0}}};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DRAW = 2'd1;
`ifdef GALVO_SCHED_SETTLE_EN
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam int SW = $clog2(SETTLE_STROBES + 1);
    localparam logic [SW-1:0]      SETTLE_C = SW'(SETTLE_STROBES);
    localparam logic [COORD_W:0]   THRESH_C = (COORD_W+1)'(JUMP_THRESH);
`endif

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || PRIME < 1 || PRIME > DEPTH ||
        SETTLE_STROBES < 1 || JUMP_THRESH < 0) begin : g_param_check
        $error("galvo_point_scheduler: illegal parameter combination");
    end

    logic [1:0]          state;
    logic [FW-1:0]       mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         count;
    logic                push;
    logic                pop;
    logic [FW-1:0]       rd_entry;
    logic                rd_mark;
    logic                rd_last;
    logic                rd_laser;
    logic [COORD_W-1:0]  rd_x;
    logic [COORD_W-1:0]  rd_y;

    assign pt_ready   = (count != DEPTH_C);
    assign fifo_count = count;
    assign push       = pt_valid && pt_ready;
    assign pop        = (state == ST_DRAW) && strobe_in && (count != '0);
    assign rd_entry   = mem[rd_ptr];
    // The top bit marks a slot written since reset; it qualifies dac_load.
    assign {rd_mark, rd_last, rd_laser, rd_x, rd_y} = rd_entry;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= {1'b1, pt_last, pt_laser, pt_x, pt_y};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef GALVO_SCHED_SETTLE_EN
    logic signed [COORD_W:0] dx;
    logic signed [COORD_W:0] dy;
    logic                    large_jump;
    logic [SW-1:0]           settle_cnt;
    logic                    held_laser;

    function automatic logic [COORD_W:0] abs_coord(input logic signed [COORD_W:0] d);
        logic [COORD_W:0] u;
        u = d;
        return d[COORD_W] ? (~u + 1'b1) : u;
    endfunction

    // One extra bit keeps the full +/- span of an unsigned coordinate difference.
    assign dx = $signed({1'b0, rd_x}) - $signed({1'b0, dac_x});
    assign dy = $signed({1'b0, rd_y}) - $signed({1'b0, dac_y});
    assign large_jump = (abs_coord(dx) > THRESH_C) || (abs_coord(dy) > THRESH_C);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            dac_x        <= CENTRE;
            dac_y        <= CENTRE;
            dac_load     <= 1'b0;
            laser_en     <= 1'b0;
            rate_setting <= 2'd0;
            frame_done   <= 1'b0;
            underflow    <= 1'b0;
`ifdef GALVO_SCHED_SETTLE_EN
            settle_cnt   <= '0;
            held_laser   <= 1'b0;
`endif
        end else begin
            dac_load   <= 1'b0;
            frame_done <= 1'b0;
            underflow  <= 1'b0;
`ifdef GALVO_SCHED_SETTLE_EN
            rate_setting <= (state == ST_SETTLE) ? 2'd0 : base_rate;
`else
            rate_setting <= base_rate;
`endif
            case (state)
                ST_IDLE: begin
                    laser_en <= 1'b0;
                    if (count >= PRIME_C) begin
                        state <= ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    if (strobe_in) begin
                        if (count == '0) begin
                            underflow <= 1'b1;
                            laser_en  <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            dac_x      <= rd_x;
                            dac_y      <= rd_y;
                            dac_load   <= rd_mark;
                            frame_done <= rd_last;
`ifdef GALVO_SCHED_SETTLE_EN
                            if (large_jump) begin
                                laser_en   <= 1'b0;
                                held_laser <= rd_laser;
                                settle_cnt <= SETTLE_C;
                                state      <= ST_SETTLE;
                            end else begin
                                laser_en <= rd_laser;
                            end
`else
                            laser_en <= rd_laser;
`endif
                        end
                    end
                end
`ifdef GALVO_SCHED_SETTLE_EN
                ST_SETTLE: begin
                    if (strobe_in) begin
                        settle_cnt <= settle_cnt - 1'b1;
                        if (settle_cnt == SW'(1)) begin
                            laser_en <= held_laser;
                            state    <= ST_DRAW;
                        end
                    end
                end
`endif
                default: begin
                    laser_en <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_galvo_point_scheduler.sv
// Scoreboard bench for galvo_point_scheduler; expectations follow GALVO_SCHED_SETTLE_EN.
module tb_galvo_point_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        strobe_in;
    logic [1:0]  base_rate;
    logic        pt_valid;
    logic [11:0] pt_x;
    logic [11:0] pt_y;
    logic        pt_laser;
    logic        pt_last;
    logic        pt_ready;
    logic [11:0] dac_x;
    logic [11:0] dac_y;
    logic        dac_load;
    logic        laser_en;
    logic [1:0]  rate_setting;
    logic        frame_done;
    logic        underflow;
    logic [4:0]  fifo_count;

    galvo_point_scheduler dut (
        .clk(clk), .reset(reset), .strobe_in(strobe_in), .base_rate(base_rate),
        .pt_valid(pt_valid), .pt_x(pt_x), .pt_y(pt_y), .pt_laser(pt_laser), .pt_last(pt_last),
        .pt_ready(pt_ready), .dac_x(dac_x), .dac_y(dac_y), .dac_load(dac_load),
        .laser_en(laser_en), .rate_setting(rate_setting), .frame_done(frame_done),
        .underflow(underflow), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        bit laser;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int n_loads = 0;
    int n_uf = 0;
    int load_seen = 0;
    int uf_seen = 0;
    int mx = 2048;
    int my = 2048;

    always @(negedge clk) begin
        if (dac_load) load_seen++;
        if (underflow) uf_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int abs_i(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic void model_push(input int x, input int y, input bit laser, input bit last);
        exp_t e;
        bit jmp;
        jmp = 1'b0;
`ifdef GALVO_SCHED_SETTLE_EN
        jmp = (abs_i(x - mx) > 256) || (abs_i(y - my) > 256);
`endif
        e.x = x;
        e.y = y;
        e.laser = laser && !jmp;
        e.last = last;
        exp_q.push_back(e);
        mx = x;
        my = y;
    endfunction

    task automatic push_pt(input int x, input int y, input bit laser, input bit last);
        bit room;
        room = (exp_q.size() < 16);
        check("pt_ready", pt_ready, room);
        pt_x = 12'(x);
        pt_y = 12'(y);
        pt_laser = laser;
        pt_last = last;
        pt_valid = 1'b1;
        tick();
        pt_valid = 1'b0;
        if (room) model_push(x, y, laser, last);
    endtask

    task automatic strobe(input bit exp_load, input bit exp_uf);
        exp_t e;
        strobe_in = 1'b1;
        tick();
        strobe_in = 1'b0;
        check("dac_load", dac_load, exp_load);
        check("underflow", underflow, exp_uf);
        if (exp_uf) begin
            n_uf++;
            check("uf_laser", laser_en, 0);
        end
        if (exp_load) begin
            n_loads++;
            check("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("dac_x", dac_x, e.x);
                check("dac_y", dac_y, e.y);
                check("laser_en", laser_en, e.laser);
                check("frame_done", frame_done, e.last);
            end
        end else begin
            check("frame_done_idle", frame_done, 0);
        end
        repeat (2) tick();
    endtask

    initial begin
        reset = 1'b0;
        strobe_in = 1'b0;
        pt_valid = 1'b0;
        pt_x = '0;
        pt_y = '0;
        pt_laser = 1'b0;
        pt_last = 1'b0;
        base_rate = 2'd3;
        #2 reset = 1'b1;
        repeat (2) tick();
        check("rst_dac_x", dac_x, 2048);
        check("rst_dac_y", dac_y, 2048);
        check("rst_laser", laser_en, 0);
        check("rst_load", dac_load, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_underflow", underflow, 0);
        check("rst_rate", rate_setting, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ready", pt_ready, 1);
        reset = 1'b0;
        tick();

        // priming: three points are not enough to leave IDLE
        push_pt(2048, 2048, 1, 0); strobe(0, 0); repeat (8) tick();
        push_pt(2100, 2100, 1, 0); strobe(0, 0); repeat (8) tick();
        push_pt(2200, 2048, 0, 0); strobe(0, 0); repeat (8) tick();
        check("prime_hold_x", dac_x, 2048);
        check("prime_hold_y", dac_y, 2048);
        push_pt(2200, 2100, 1, 0);
        strobe(0, 0);
        check("prime_count", fifo_count, 4);

        // small moves
        strobe(1, 0); check("rate_small1", rate_setting, 3);
        strobe(1, 0); check("rate_small2", rate_setting, 3);
        strobe(1, 0); check("rate_small3", rate_setting, 3);
        strobe(1, 0);
        strobe(0, 1);
        check("uf1_count", fifo_count, 0);

        // large jump from 2048 to 3000
        push_pt(2048, 2048, 1, 0);
        push_pt(3000, 2048, 1, 1);
        push_pt(3010, 2048, 1, 0);
        push_pt(3020, 2048, 0, 0);
        tick();
        strobe(1, 0);
        strobe(1, 0);
`ifdef GALVO_SCHED_SETTLE_EN
        check("jump_rate", rate_setting, 0);
        check("jump_laser", laser_en, 0);
        strobe(0, 0);
        check("settle1_laser", laser_en, 0);
        check("settle1_rate", rate_setting, 0);
        check("settle1_count", fifo_count, 2);
        strobe(0, 0);
        check("settle2_laser", laser_en, 1);
        check("settle2_rate", rate_setting, 3);
        check("settle2_count", fifo_count, 2);
        strobe(1, 0);
        strobe(1, 0);
`else
        check("jump_rate", rate_setting, 3);
        strobe(1, 0);
        check("after_jump_rate", rate_setting, 3);
        strobe(1, 0);
`endif
        strobe(0, 1);

        // fill to full, drop one, drain past empty
        for (int i = 0; i < 16; i++) begin
            push_pt(3024 + 4 * i, 2048, (i % 2) == 0, 0);
        end
        check("full_count", fifo_count, 16);
        push_pt(3500, 2048, 1, 0);
        check("full_drop_count", fifo_count, 16);
        repeat (16) strobe(1, 0);

        // push coinciding with strobe on an empty FIFO still underflows
        pt_x = 12'd3090;
        pt_y = 12'd2048;
        pt_laser = 1'b1;
        pt_last = 1'b0;
        pt_valid = 1'b1;
        strobe_in = 1'b1;
        tick();
        pt_valid = 1'b0;
        strobe_in = 1'b0;
        model_push(3090, 2048, 1, 0);
        n_uf++;
        check("uf2_pulse", underflow, 1);
        check("uf2_load", dac_load, 0);
        check("uf2_laser", laser_en, 0);
        check("uf2_hold_x", dac_x, 3084);
        tick();
        check("uf2_count", fifo_count, 1);
        strobe(0, 0);
        check("idle_count", fifo_count, 1);

        // frame end, then asynchronous reset between edges
        push_pt(3095, 2048, 1, 0);
        push_pt(3100, 2048, 1, 1);
        push_pt(3105, 2048, 1, 0);
        tick();
        strobe(1, 0);
        strobe(1, 0);
        strobe(1, 0);
        check("pre_reset_laser", laser_en, 1);
        #3 reset = 1'b1;
        #1;
        check("async_laser", laser_en, 0);
        check("async_count", fifo_count, 0);
        check("async_dac_x", dac_x, 2048);
        check("async_ready", pt_ready, 1);
        exp_q.delete();
        mx = 2048;
        my = 2048;
        tick();
        reset = 1'b0;
        tick();
        check("post_reset_count", fifo_count, 0);
        check("load_total", load_seen, n_loads);
        check("underflow_total", uf_seen, n_uf);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
